if_prefetch_buffer: RTL and testbench

//   Instruction fetch front end placed directly upstream of ifstage/idstage.
//   - Issues sequential word fetches to the instruction memory over a req/gnt/rvalid bus.
//   - Buffers returned words with their PC in a DEPTH-entry in-order FIFO.
//   - Presents words to the decode side over a valid/ready handshake.
//   - Handles control-flow redirects by flushing the FIFO and discarding stale in-flight responses.
//

---
 rtl/if_prefetch_buffer.sv | 102 ++++++++++
 tb/tb_if_prefetch_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: sequential instruction prefetcher with an in-order PC-tagged FIFO and redirect flush.
// Optional feature: define IF_PREFETCH_PERF_EN to add stall_cnt_o/flush_cnt_o saturating counters.
// Ports: clk_i/rst_i clock and sync active-high reset; redirect_i/redirect_pc_i flush and restart fetch;
//   imem_req_o/imem_addr_o/imem_gnt_i/imem_rvalid_i/imem_rdata_i in-order fetch bus;
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i decode-side valid/ready handshake.
module if_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 2;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic [CW-1:0] r_out, r_disc;
  logic [31:0]   r_fetch_pc, r_resp_pc;
  logic [AW:0]   w_diff;
  logic [CW-1:0] w_occ;
  logic [31:0]   w_redir_pc;
  logic          w_gnt, w_rv, w_drop, w_push, w_pop, w_unused;
  assign w_diff        = r_wptr - r_rptr;
  assign w_occ         = {1'b0, w_diff};
  assign w_redir_pc    = {redirect_pc_i[31:2], 2'b00};
  assign w_unused      = ^redirect_pc_i[1:0];
  assign imem_req_o    = !rst_i && (w_occ + r_out < CW'(DEPTH));
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = !rst_i && (r_wptr != r_rptr);
  assign instr_o       = r_data[r_rptr[AW-1:0]];
  assign instr_pc_o    = r_pc[r_rptr[AW-1:0]];
  // A grant only counts while a request is actually presented.
  assign w_gnt  = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is a bus error and is ignored.
  assign w_rv   = imem_rvalid_i && (r_out != '0);
  assign w_drop = w_rv && (r_disc != '0);
  assign w_push = w_rv && !w_drop && !redirect_i;
  assign w_pop  = instr_valid_o && instr_ready_i && !redirect_i;
  always_ff @(posedge clk_i)
    if (w_push) begin
      r_data[r_wptr[AW-1:0]] <= imem_rdata_i;
      r_pc[r_wptr[AW-1:0]]   <= r_resp_pc;
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_out      <= '0;
      r_disc     <= '0;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
    end else begin
      r_out <= r_out + CW'(w_gnt) - CW'(w_rv);
      if (redirect_i) begin
        // Everything still in flight after this edge is stale, including a same-cycle grant.
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_disc     <= r_out + CW'(w_gnt) - CW'(w_rv);
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
      end else begin
        if (w_gnt) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_drop) r_disc <= r_disc - CW'(1);
        if (w_push) begin
          r_wptr    <= r_wptr + (AW+1)'(1);
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  a_rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i) !(imem_rvalid_i && r_out == '0));
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (instr_ready_i && !instr_valid_o && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (redirect_i && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// tb_if_prefetch_buffer: table, directed and random checks of if_prefetch_buffer against a queue model.
module tb_if_prefetch_buffer;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0;
  logic clk = 0, rst = 1, redirect = 0, gnt = 0, rvalid = 0, ready = 0;
  logic [31:0] redirect_pc = 0, rdata = 0;
  logic req, valid;
  logic [31:0] addr, instr, ipc;
  logic rst2 = 1, rvalid2 = 0;
  logic [31:0] rdata2 = 0;
  logic req2, valid2;
  logic [31:0] addr2, instr2, ipc2;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, stall2, flush2;
`endif
  always #5 clk = ~clk;
  if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) u_dut (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc), .instr_ready_i(ready)
`ifdef IF_PREFETCH_PERF_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
  );
  if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk_i(clk), .rst_i(rst2), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(1'b1), .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .instr_valid_o(valid2), .instr_o(instr2), .instr_pc_o(ipc2), .instr_ready_i(1'b1)
`ifdef IF_PREFETCH_PERF_EN
    , .stall_cnt_o(stall2), .flush_cnt_o(flush2)
`endif
  );
  typedef struct packed { logic [31:0] pc; logic stale; } pend_t;
  typedef struct packed { logic [31:0] data; logic [31:0] pc; } ent_t;
  typedef struct { logic g, rv, rdy, e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc; } vec_t;
  pend_t pq[$];
  ent_t fq[$];
  logic [31:0] fpc = RPC, stall_exp = 0, flush_exp = 0;
  int n_vec = 0, n_miss = 0, gnt_cnt = 0;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a ^ 32'hDEAD_0000) + 32'd1;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic rs, input logic rd, input logic [31:0] rpc, input logic g, input logic rv, input logic rdy);
    logic e_req, e_valid;
    pend_t p;
    rst = rs; redirect = rd; redirect_pc = rpc; ready = rdy;
    e_req = !rs && (fq.size() + pq.size() < DEPTH);
    e_valid = !rs && fq.size() != 0;
    gnt = g && e_req;
    rvalid = !rs && rv && pq.size() != 0;
    rdata = rvalid ? mdata(pq[0].pc) : $urandom;
    #1;
    s_req = req; s_addr = addr; s_valid = valid; s_pc = ipc; s_instr = instr;
    if (req && gnt) gnt_cnt++;
    chk("req", 32'(req), 32'(e_req));
    chk("valid", 32'(valid), 32'(e_valid));
    if (e_req) chk("addr", addr, fpc);
    if (e_valid) begin
      chk("head_pc", ipc, fq[0].pc);
      chk("head_instr", instr, fq[0].data);
    end
`ifdef IF_PREFETCH_PERF_EN
    if (!rs) begin
      chk("stall_cnt", stall_cnt, stall_exp);
      chk("flush_cnt", flush_cnt, flush_exp);
    end
`endif
    @(posedge clk);
    if (rs) begin
      pq.delete(); fq.delete(); fpc = RPC; stall_exp = 0; flush_exp = 0;
    end else begin
      if (rdy && fq.size() == 0) stall_exp++;
      if (rd) begin
        flush_exp++;
        if (rvalid) void'(pq.pop_front());
        foreach (pq[i]) pq[i].stale = 1'b1;
        if (gnt) pq.push_back('{fpc, 1'b1});
        fq.delete();
        fpc = {rpc[31:2], 2'b00};
      end else begin
        if (rdy && fq.size() != 0) void'(fq.pop_front());
        if (rvalid) begin
          p = pq.pop_front();
          if (!p.stale) fq.push_back('{mdata(p.pc), p.pc});
        end
        if (gnt) begin
          pq.push_back('{fpc, 1'b0});
          fpc = fpc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic wait_head(input string nm, input logic [31:0] pc);
    int k;
    for (k = 0; k < 40; k++) begin
      step(0, 0, 0, 1, 1, 0);
      if (s_valid) break;
    end
    chk({nm, "_seen"}, 32'(k < 40), 32'd1);
    if (k < 40) begin
      chk({nm, "_pc"}, s_pc, pc);
      chk({nm, "_instr"}, s_instr, mdata(pc));
    end
  endtask
  initial begin
    vec_t tab[5];
    int pend2;
    logic r2;
    logic [31:0] wexp[3];
    tab[0] = '{1, 0, 1, 1, 32'h0,  0, 32'h0};
    tab[1] = '{1, 1, 1, 1, 32'h4,  0, 32'h0};
    tab[2] = '{1, 1, 1, 1, 32'h8,  1, 32'h0};
    tab[3] = '{1, 1, 1, 1, 32'hC,  1, 32'h4};
    tab[4] = '{1, 1, 1, 1, 32'h10, 1, 32'h8};
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, tab[i].g, tab[i].rv, tab[i].rdy);
      chk($sformatf("t1_req[%0d]", i), 32'(s_req), 32'(tab[i].e_req));
      chk($sformatf("t1_addr[%0d]", i), s_addr, tab[i].e_addr);
      chk($sformatf("t1_valid[%0d]", i), 32'(s_valid), 32'(tab[i].e_valid));
      if (tab[i].e_valid) chk($sformatf("t1_pc[%0d]", i), s_pc, tab[i].e_pc);
    end
    step(1, 0, 0, 0, 0, 0);
    gnt_cnt = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 0);
    chk("t2_gnts", 32'(gnt_cnt), 32'd4);
    chk("t2_full_valid", 32'(s_valid), 32'd1);
    chk("t2_full_req", 32'(s_req), 32'd0);
    step(0, 0, 0, 1, 1, 1);
    gnt_cnt = 0;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0);
    chk("t2_refill_gnts", 32'(gnt_cnt), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1);
    step(0, 1, 32'h0000_0103, 0, 0, 1);
    wait_head("t3", 32'h100);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 1, 32'h100, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_valid", 32'(s_valid), 32'd0);
    chk("t4_addr", s_addr, 32'h100);
    chk("t4_req", 32'(s_req), 32'd1);
    wait_head("t4", 32'h100);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h200, 0, 0, 0);
    step(0, 1, 32'h300, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
`ifdef IF_PREFETCH_PERF_EN
    chk("t6_stall", stall_cnt, 32'd5);
    chk("t6_flush", flush_cnt, 32'd2);
`endif
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    rst2 = 1;
    @(posedge clk);
    @(negedge clk);
    rst2 = 0;
    pend2 = 0;
    for (int c = 0; c < 6; c++) begin
      rvalid2 = pend2 > 0;
      rdata2 = 32'(c);
      #1;
      r2 = req2;
      if (c < 3) begin
        chk($sformatf("t5_req[%0d]", c), 32'(req2), 32'd1);
        chk($sformatf("t5_addr[%0d]", c), addr2, wexp[c]);
      end
      @(posedge clk);
      pend2 = pend2 + int'(r2) - int'(rvalid2);
      @(negedge clk);
    end
    rst2 = 1;
    rvalid2 = 0;
    #1;
    chk("t5_rst_req", 32'(req2), 32'd0);
    chk("t5_rst_valid", 32'(valid2), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst2 = 0;
    #1;
    chk("t5_restart_req", 32'(req2), 32'd1);
    chk("t5_restart_addr", addr2, 32'hFFFF_FFF8);
    chk("t5_restart_valid", 32'(valid2), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
